// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: shared state, PC_sel and instruction-field definitions for the fetch stage
package fetch_pc_unit_pkg;
    typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_JR  = 2'b01;
    localparam logic [1:0] PCSEL_BR  = 2'b10;
    localparam logic [1:0] PCSEL_J   = 2'b11;
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 13;
    localparam int FUNC_MSB  = 3;
    localparam int FUNC_LSB  = 0;
    localparam int IMM7_MSB  = 6;
    localparam int IMM7_LSB  = 0;
    localparam int JADDR_MSB = 12;
    localparam int JADDR_LSB = 0;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
endpackage

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory req/ack fetch port
interface fetch_pc_unit_if #(parameter int ADDR_W = 16);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_ack;
    modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/fetch_pc_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection from PC_sel, wrapping modulo 2^ADDR_W
module next_pc_calc
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [JADDR_MSB:0] instr,
    input  logic [15:0]        rs_data,
    input  logic [1:0]         PC_sel,
    output logic [ADDR_W-1:0]  next_pc,
    output logic [ADDR_W-1:0]  pc_plus1
);
    logic [ADDR_W-1:0] imm;
    always_comb begin
        pc_plus1 = pc + ADDR_W'(1);
        imm      = {{(ADDR_W-7){instr[IMM7_MSB]}}, instr[IMM7_MSB:IMM7_LSB]};
        // X/Z on PC_sel falls through to the sequential default
        case (PC_sel)
            PCSEL_JR: next_pc = rs_data[ADDR_W-1:0];
            PCSEL_BR: next_pc = pc_plus1 + imm;
            PCSEL_J:  next_pc = {pc_plus1[ADDR_W-1:JADDR_MSB+1], instr[JADDR_MSB:JADDR_LSB]};
            default:  next_pc = pc_plus1;
        endcase
    end
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and req/ack instruction fetch FSM feeding the control unit
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_pc_unit_if.master     imem,
    output logic [15:0]         instr,
    output logic                instr_valid,
    output logic [2:0]          opcode,
    output logic [3:0]          function_extend,
    input  logic [1:0]          PC_sel,
    input  logic                HLT_RST,
    input  logic                ex_stall,
    input  logic [15:0]         rs_data,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   pc_plus1,
    output logic                halted
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
    logic [15:0]       instr_q, instr_d;
    logic              valid_q, valid_d, halted_q, halted_d;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc       (pc_q),
        .instr    (instr_q[JADDR_MSB:0]),
        .rs_data  (rs_data),
        .PC_sel   (PC_sel),
        .next_pc  (next_pc),
        .pc_plus1 (pc_plus1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            FETCH: if (imem.imem_ack) begin
                instr_d = imem.imem_rdata;
                valid_d = 1'b1;
                state_d = EXEC;
            end
            EXEC: if (!HLT_RST) begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
                state_d  = HALT;
            end else if (!ex_stall) begin
                pc_d    = next_pc;
                valid_d = 1'b0;
                state_d = FETCH;
            end
            default: ;
        endcase
    end

    // request is gated by rst_n so it drops the instant reset asserts
    always_comb begin
        imem.imem_req   = rst_n && (state_q == FETCH);
        imem.imem_addr  = pc_q;
        instr           = instr_q;
        instr_valid     = valid_q;
        opcode          = instr_q[OPC_MSB:OPC_LSB];
        function_extend = instr_q[FUNC_MSB:FUNC_LSB];
        pc              = pc_q;
        halted          = halted_q;
    end
endmodule
